closest_hit_tracker: RTL and testbench
======================================

// Module: closest_hit_tracker
// PURPOSE
//  Downstream of the pipelined ray/triangle intersection stage. Consumes its in-order
//  per-triangle result stream (t, hit, valid) for one ray at a time. Reduces it to the
//  closest valid hit: minimum t plus the triangle index.
//  Presents one result per ray to the shading/writeback stage with a valid/ready handshake.
// PARAMETERS
//  IDX_W   16            width of triangle count/index
//  T_W     32            width of t (Q16.16 signed fixed point, FIP format)
// PORTS
//  i_clk       in   1      clock; all state on rising edge
//  i_rst       in   1      reset, synchronous, active-high
//  i_start     in   1      begin a new ray; accepted only in IDLE
//  i_num_tris  in   IDX_W  triangles to expect for this ray, sampled on accepted i_start
//  o_busy      out  1      high in ACCUM or DONE; i_start ignored while high
//  i_valid     in   1      intersection result valid (one per triangle, in issue order)
//  i_t         in   T_W    signed t of this result
//  i_hit       in   1      intersection result flag (already filtered by min_t upstream)
//  o_valid     out  1      closest-hit result available
//  i_ready     in   1      consumer accepts result
//  o_hit       out  1      any triangle hit
//  o_t         out  T_W    closest t; FIP_MAX when no hit
//  o_tri_idx   out  IDX_W  0-based index of closest triangle; 0 when no hit
//  o_overrun   out  1      sticky error: i_valid seen outside ACCUM; cleared only by i_rst
// BEHAVIOUR
//  - Reset (i_rst high at edge): state=IDLE, o_valid=0, o_busy=0, o_hit=0,
//    o_t=32'sh7fffffff, o_tri_idx=0, o_overrun=0, counter=0. Reset mid-ray aborts it.
//  - All outputs are registered; no combinational input->output paths.
//  - FSM IDLE -> ACCUM: i_start in IDLE with i_num_tris!=0.
//    - Latch N. Set cnt=0, best_t=FIP_MAX, best_hit=0, best_idx=0.
//  - FSM IDLE -> DONE: i_start with i_num_tris==0.
//    - Next cycle o_valid=1, o_hit=0, o_t=FIP_MAX, o_tri_idx=0.
//  - ACCUM, on each i_valid:
//    - If i_hit && (!best_hit || i_t < best_t): update best_t=i_t, best_idx=cnt, best_hit=1.
//    - Signed compare. Strict < so ties keep the lowest index.
//    - Then cnt++. If cnt==N-1 at this result -> DONE.
//  - Latency: o_valid rises the cycle after the N-th i_valid; the result includes that last triangle.
//  - DONE: o_valid=1 and outputs stable until o_valid&&i_ready, then IDLE next cycle (o_valid=0).
//  - i_start during ACCUM/DONE, including the ack cycle, is ignored; it is not queued.
//  - Gaps (i_valid low) in ACCUM are allowed and hold all state.
//  - Upstream has no backpressure, so no ray's results may arrive while in IDLE/DONE.
//    - Any such i_valid is dropped and sets o_overrun.
//    - i_valid coincident with an accepted i_start counts as overrun.
//  - Counter wraps are impossible: cnt < N <= 2^IDX_W-1.
// STRUCTURE
//  - Shared package (fip_pkg): FIP_ONE, FIP_MIN, FIP_MAX constants, fip_t typedef (signed [31:0]),
//    and the chit_state_e enum {IDLE, ACCUM, DONE}.
//  - Single flat module; no sub-module is warranted: the compare/select is one comparator and
//    three registers.
// TESTING
//  1. N=3, results (hit,t)=(1,5.0),(1,2.0),(1,3.0) back-to-back
//     -> o_valid 1 cycle after 3rd; o_hit=1, o_t=0x00020000, o_tri_idx=1.
//  2. N=4, all i_hit=0 with gaps of 2 idle cycles
//     -> o_hit=0, o_t=0x7fffffff, o_tri_idx=0; o_valid only after the 4th result.
//  3. N=2 tie, (1,1.0),(1,1.0)                          -> o_tri_idx=0.
//     Negative t (1,-0.5),(1,1.0)                       -> o_t=0xffff8000, idx 0.
//  4. N=0 start -> o_valid next cycle with no-hit values.
//     Hold i_ready=0 for 5 cycles -> outputs stable. i_start during the hold is ignored.
//  5. i_valid in IDLE                                   -> o_overrun=1 and stays set.
//     Reset in ACCUM after 1 of 3 results -> all outputs at reset values next cycle;
//     a new ray then completes normally.
//  6. Back-to-back rays: ack cycle, then i_start next cycle
//     -> second ray result is independent of the first (best_t reinitialised).

Source files
------------

// File: rtl/fip_pkg.sv
// Shared Q16.16 fixed-point (FIP) definitions and closest-hit tracker state encoding.
package fip_pkg;

    localparam int unsigned FIP_W = 32;

    typedef logic signed [FIP_W-1:0] fip_t;

    localparam fip_t FIP_ONE = 32'sh0001_0000;
    localparam fip_t FIP_MIN = 32'sh8000_0000;
    localparam fip_t FIP_MAX = 32'sh7fff_ffff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } chit_state_e;

endpackage : fip_pkg

// File: rtl/closest_hit_tracker.sv
// Reduces the in-order per-triangle intersection stream of one ray to its closest hit
// (minimum signed t and triangle index) and presents it with a valid/ready handshake.
module closest_hit_tracker
    import fip_pkg::*;
#(
    parameter int unsigned IDX_W = 16,
    parameter int unsigned T_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [IDX_W-1:0] i_num_tris,
    output logic             o_busy,
    input  logic             i_valid,
    input  logic [T_W-1:0]   i_t,
    input  logic             i_hit,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_hit,
    output logic [T_W-1:0]   o_t,
    output logic [IDX_W-1:0] o_tri_idx,
    output logic             o_overrun
);

    chit_state_e      state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] num_q, num_d;
    logic             hit_d;
    logic [T_W-1:0]   t_d;
    logic [IDX_W-1:0] idx_d;
    logic             overrun_d;
    logic             closer_c;

    // Strict signed less-than: equal t never displaces an earlier (lower-index) hit.
    assign closer_c = i_hit && (!o_hit || ($signed(i_t) < $signed(o_t)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            num_q     <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_hit     <= 1'b0;
            o_t       <= T_W'(FIP_MAX);
            o_tri_idx <= '0;
            o_overrun <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            o_valid   <= (state_d == DONE);
            o_busy    <= (state_d != IDLE);
            o_hit     <= hit_d;
            o_t       <= t_d;
            o_tri_idx <= idx_d;
            o_overrun <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        hit_d     = o_hit;
        t_d       = o_t;
        idx_d     = o_tri_idx;
        // Upstream cannot stall, so a result outside ACCUM is lost and flagged.
        overrun_d = o_overrun | (i_valid && (state_q != ACCUM));

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    num_d   = i_num_tris;
                    cnt_d   = '0;
                    hit_d   = 1'b0;
                    t_d     = T_W'(FIP_MAX);
                    idx_d   = '0;
                    state_d = (i_num_tris == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (i_valid) begin
                    if (closer_c) begin
                        hit_d = 1'b1;
                        t_d   = i_t;
                        idx_d = cnt_q;
                    end
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == (num_q - IDX_W'(1))) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule : closest_hit_tracker

// File: tb/tb_closest_hit_tracker.sv
// Directed self-checking bench for closest_hit_tracker.
module tb_closest_hit_tracker;

    localparam int unsigned IDX_W = 16;
    localparam int unsigned T_W   = 32;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic [IDX_W-1:0] i_num_tris;
    logic             o_busy;
    logic             i_valid;
    logic [T_W-1:0]   i_t;
    logic             i_hit;
    logic             o_valid;
    logic             i_ready;
    logic             o_hit;
    logic [T_W-1:0]   o_t;
    logic [IDX_W-1:0] o_tri_idx;
    logic             o_overrun;

    int tests = 0;
    int fails = 0;

    closest_hit_tracker #(.IDX_W(IDX_W), .T_W(T_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_num_tris (i_num_tris),
        .o_busy     (o_busy),
        .i_valid    (i_valid),
        .i_t        (i_t),
        .i_hit      (i_hit),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_hit      (o_hit),
        .o_t        (o_t),
        .o_tri_idx  (o_tri_idx),
        .o_overrun  (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_ray(input logic [IDX_W-1:0] n);
        i_start    = 1'b1;
        i_num_tris = n;
        tick();
        i_start    = 1'b0;
    endtask

    task automatic send(input logic hit, input logic [T_W-1:0] t);
        i_valid = 1'b1;
        i_hit   = hit;
        i_t     = t;
        tick();
        i_valid = 1'b0;
        i_hit   = 1'b0;
    endtask

    task automatic ack();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic hit, input logic [T_W-1:0] t,
                              input logic [IDX_W-1:0] idx);
        chk({tag, "_valid"}, 64'(o_valid), 64'(1'b1));
        chk({tag, "_hit"}, 64'(o_hit), 64'(hit));
        chk({tag, "_t"}, 64'(o_t), 64'(t));
        chk({tag, "_idx"}, 64'(o_tri_idx), 64'(idx));
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_num_tris = '0; i_valid = 1'b0;
        i_t = '0; i_hit = 1'b0; i_ready = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        chk("rst_valid", 64'(o_valid), 64'(1'b0));
        chk("rst_busy", 64'(o_busy), 64'(1'b0));
        chk("rst_hit", 64'(o_hit), 64'(1'b0));
        chk("rst_t", 64'(o_t), 64'h7fffffff);
        chk("rst_idx", 64'(o_tri_idx), 64'd0);
        chk("rst_overrun", 64'(o_overrun), 64'(1'b0));

        // 1: closest is the middle triangle
        start_ray(16'd3);
        chk("t1_busy", 64'(o_busy), 64'(1'b1));
        send(1'b1, 32'h0005_0000);
        send(1'b1, 32'h0002_0000);
        chk("t1_notyet", 64'(o_valid), 64'(1'b0));
        send(1'b1, 32'h0003_0000);
        chk_result("t1", 1'b1, 32'h0002_0000, 16'd1);
        ack();
        chk("t1_ack_valid", 64'(o_valid), 64'(1'b0));
        chk("t1_ack_busy", 64'(o_busy), 64'(1'b0));

        // 2: all misses with gaps
        start_ray(16'd4);
        for (int k = 0; k < 4; k++) begin
            chk("t2_gap_valid", 64'(o_valid), 64'(1'b0));
            send(1'b0, 32'h0001_0000);
            if (k < 3) begin
                tick();
                tick();
            end
        end
        chk_result("t2", 1'b0, 32'h7fff_ffff, 16'd0);
        ack();

        // 3a: tie keeps lowest index
        start_ray(16'd2);
        send(1'b1, 32'h0001_0000);
        send(1'b1, 32'h0001_0000);
        chk_result("t3tie", 1'b1, 32'h0001_0000, 16'd0);
        ack();

        // 3b: negative t wins
        start_ray(16'd2);
        send(1'b1, 32'hffff_8000);
        send(1'b1, 32'h0001_0000);
        chk_result("t3neg", 1'b1, 32'hffff_8000, 16'd0);
        ack();

        // 4: zero triangles, held result, ignored start
        start_ray(16'd0);
        chk_result("t4", 1'b0, 32'h7fff_ffff, 16'd0);
        i_start    = 1'b1;
        i_num_tris = 16'd5;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_result("t4_hold", 1'b0, 32'h7fff_ffff, 16'd0);
        end
        i_start = 1'b0;
        ack();
        chk("t4_idle_busy", 64'(o_busy), 64'(1'b0));
        chk("t4_no_overrun", 64'(o_overrun), 64'(1'b0));

        // 5: overrun in IDLE is sticky
        send(1'b1, 32'h0001_0000);
        chk("t5_overrun", 64'(o_overrun), 64'(1'b1));
        chk("t5_idle_valid", 64'(o_valid), 64'(1'b0));
        tick();
        tick();
        chk("t5_overrun_sticky", 64'(o_overrun), 64'(1'b1));

        // 5b: reset mid-ray, then a normal ray
        start_ray(16'd3);
        send(1'b1, 32'h0000_1000);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t5r_valid", 64'(o_valid), 64'(1'b0));
        chk("t5r_busy", 64'(o_busy), 64'(1'b0));
        chk("t5r_hit", 64'(o_hit), 64'(1'b0));
        chk("t5r_t", 64'(o_t), 64'h7fffffff);
        chk("t5r_idx", 64'(o_tri_idx), 64'd0);
        chk("t5r_overrun", 64'(o_overrun), 64'(1'b0));
        start_ray(16'd3);
        send(1'b1, 32'h0004_0000);
        send(1'b0, 32'h0001_0000);
        send(1'b1, 32'hfffe_0000);
        chk_result("t5n", 1'b1, 32'hfffe_0000, 16'd2);

        // 6: start during ack is ignored, next ray is independent
        i_start    = 1'b1;
        i_num_tris = 16'd7;
        ack();
        i_start = 1'b0;
        chk("t6_ack_start_ignored", 64'(o_busy), 64'(1'b0));
        start_ray(16'd2);
        send(1'b0, 32'h0001_0000);
        send(1'b1, 32'h0007_0000);
        chk_result("t6", 1'b1, 32'h0007_0000, 16'd1);
        ack();
        chk("t6_final_overrun", 64'(o_overrun), 64'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_closest_hit_tracker
